// File: rtl/display_plane_scaler.sv
// display_plane_scaler
// Streams a SRC_W x SRC_H image from the pixel ROM into the VGA output FIFO,
// replicating every pixel H_SCALE times across and every line V_SCALE times down.
// The next ROM fetch runs while the current pixel is being replicated.
//
//  state | meaning
//  ------+------------------------------------------------------------------
//  WAIT  | post-reset delay of START_DLY cycles while the FIFO initialises
//  IDLE  | between frames; on enable, fetch pixel (0,0)
//  FILL  | waiting for the first pixel of the frame to return from ROM
//  EMIT  | writing cur_pix H_SCALE times; the following pixel is in flight
//  STALL | replication finished before the prefetched pixel arrived
module display_plane_scaler #(
    parameter int SRC_W     = 80,
    parameter int SRC_H     = 60,
    parameter int H_SCALE   = 8,
    parameter int V_SCALE   = 8,
    parameter int PIX_W     = 24,
    parameter int ADDR_W    = 13,
    parameter int RD_LAT    = 1,
    parameter int START_DLY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_full,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic [ADDR_W-1:0] addr,
    output logic              rom_rd,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              fifo_write,
    output logic              frame_start,
    output logic              line_end
);
    localparam int XW = $clog2(SRC_W) + 1;
    localparam int YW = $clog2(SRC_H) + 1;
    localparam int HW = $clog2(H_SCALE) + 1;
    localparam int VW = $clog2(V_SCALE) + 1;
    localparam int DW = $clog2(START_DLY + 1) + 1;

    localparam logic [XW-1:0] X_LAST   = XW'(SRC_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(SRC_H - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_SCALE - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_SCALE - 1);
    localparam logic [DW-1:0] DLY_INIT = DW'(START_DLY);

    typedef enum logic [2:0] {S_WAIT, S_IDLE, S_FILL, S_EMIT, S_STALL} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]     dly_cnt;
    logic [RD_LAT-1:0] rd_pipe;
    logic              data_vld;

    // emit position: the pixel currently held in cur_pix
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [HW-1:0]     hrep;
    logic [VW-1:0]     vrep;

    // fetch position: the next pixel to request from ROM
    logic [XW-1:0]     fx;
    logic [YW-1:0]     fy;
    logic [VW-1:0]     fvrep;
    logic [ADDR_W-1:0] row_base;
    logic              fetch_done;
    logic              fetch_wrap;

    logic [PIX_W-1:0]  cur_pix;
    logic [PIX_W-1:0]  nxt_pix;
    logic              nxt_vld;

    logic              do_fetch;
    logic              ld_rom;
    logic              ld_nxt;
    logic              frame_end;

    assign data_vld   = rd_pipe[RD_LAT-1];
    assign frame_end  = (x == X_LAST) && (vrep == V_LAST) && (y == Y_LAST);
    assign fetch_wrap = (fx == X_LAST) && (fvrep == V_LAST) && (fy == Y_LAST);
    assign pixel_out  = cur_pix;

    assign frame_start = fifo_write && (x == '0) && (y == '0) && (vrep == '0) && (hrep == '0);
    assign line_end    = fifo_write && (x == X_LAST) && (hrep == H_LAST);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, write strobe and fetch/load decisions
    always_comb begin
        state_nxt  = state;
        do_fetch   = 1'b0;
        ld_rom     = 1'b0;
        ld_nxt     = 1'b0;
        fifo_write = 1'b0;
        case (state)
            S_WAIT: begin
                if (dly_cnt <= DW'(1)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (enable) begin
                    do_fetch  = 1'b1;
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (data_vld) begin
                    ld_rom    = 1'b1;
                    do_fetch  = !fetch_done;
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                fifo_write = !fifo_full;
                if (!fifo_full && (hrep == H_LAST)) begin
                    if (frame_end) begin
                        state_nxt = S_IDLE;
                    end else if (nxt_vld) begin
                        ld_nxt   = 1'b1;
                        do_fetch = !fetch_done;
                    end else begin
                        state_nxt = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (nxt_vld) begin
                    ld_nxt    = 1'b1;
                    do_fetch  = !fetch_done;
                    state_nxt = S_EMIT;
                end
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // start-up delay, ROM request pipeline and pixel registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_cnt <= DLY_INIT;
            rd_pipe <= '0;
            rom_rd  <= 1'b0;
            cur_pix <= '0;
            nxt_pix <= '0;
            nxt_vld <= 1'b0;
        end else begin
            if ((state == S_WAIT) && (dly_cnt != '0)) begin
                dly_cnt <= dly_cnt - 1'b1;
            end
            rom_rd     <= do_fetch;
            rd_pipe[0] <= rom_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (ld_rom) begin
                cur_pix <= pixel_in;
            end else if (ld_nxt) begin
                cur_pix <= nxt_pix;
            end
            // only one prefetch is ever in flight, so set and clear never collide
            if (ld_nxt) begin
                nxt_vld <= 1'b0;
            end
            if (data_vld && (state != S_FILL)) begin
                nxt_pix <= pixel_in;
                nxt_vld <= 1'b1;
            end
        end
    end

    // fetch pointer; wraps after the last pixel of the frame, which blocks further prefetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr       <= '0;
            fx         <= '0;
            fy         <= '0;
            fvrep      <= '0;
            row_base   <= '0;
            fetch_done <= 1'b0;
        end else if (do_fetch) begin
            addr       <= row_base + ADDR_W'(fx);
            fetch_done <= fetch_wrap;
            if (fx == X_LAST) begin
                fx <= '0;
                if (fvrep == V_LAST) begin
                    fvrep <= '0;
                    if (fy == Y_LAST) begin
                        fy       <= '0;
                        row_base <= '0;
                    end else begin
                        fy       <= fy + 1'b1;
                        row_base <= row_base + ADDR_W'(SRC_W);
                    end
                end else begin
                    fvrep <= fvrep + 1'b1;
                end
            end else begin
                fx <= fx + 1'b1;
            end
        end
    end

    // emit position advances only on an accepted write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            hrep <= '0;
            vrep <= '0;
        end else if (fifo_write) begin
            if (hrep == H_LAST) begin
                hrep <= '0;
                if (x == X_LAST) begin
                    x <= '0;
                    if (vrep == V_LAST) begin
                        vrep <= '0;
                        y    <= (y == Y_LAST) ? '0 : y + 1'b1;
                    end else begin
                        vrep <= vrep + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end else begin
                hrep <= hrep + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_plane_scaler.sv
// Bench for display_plane_scaler: a small-image instance with backpressure, enable and
// reset sequences, plus an H_SCALE=1/RD_LAT=2 instance that exercises the STALL path.
module tb_display_plane_scaler;
    localparam int PIX_W    = 24;
    localparam int ADDR_W   = 13;
    localparam int DLY      = 4;

    localparam int SRC_W_A  = 6;
    localparam int SRC_H_A  = 4;
    localparam int H_A      = 3;
    localparam int V_A      = 2;
    localparam int RD_LAT_A = 1;
    localparam int FRAME_WR = SRC_W_A * H_A * SRC_H_A * V_A;
    localparam int FRAME_RD = SRC_W_A * SRC_H_A * V_A;
    localparam int LINES    = SRC_H_A * V_A;
    localparam int FIRST_WR = DLY + 2 + RD_LAT_A;

    localparam int SRC_W_B  = 5;
    localparam int SRC_H_B  = 3;
    localparam int RD_LAT_B = 2;
    localparam int FRAME_B  = SRC_W_B * SRC_H_B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable_a = 1'b0, fifo_full_a = 1'b0;
    logic enable_b = 1'b0, fifo_full_b = 1'b0;
    logic [PIX_W-1:0]  pixel_in_a, pixel_in_b, pixel_out_a, pixel_out_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic rom_rd_a, rom_rd_b, fifo_write_a, fifo_write_b;
    logic frame_start_a, frame_start_b, line_end_a, line_end_b;

    display_plane_scaler #(
        .SRC_W(SRC_W_A), .SRC_H(SRC_H_A), .H_SCALE(H_A), .V_SCALE(V_A), .PIX_W(PIX_W),
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT_A), .START_DLY(DLY)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a), .fifo_full(fifo_full_a),
        .pixel_in(pixel_in_a), .addr(addr_a), .rom_rd(rom_rd_a), .pixel_out(pixel_out_a),
        .fifo_write(fifo_write_a), .frame_start(frame_start_a), .line_end(line_end_a)
    );

    display_plane_scaler #(
        .SRC_W(SRC_W_B), .SRC_H(SRC_H_B), .H_SCALE(1), .V_SCALE(1), .PIX_W(PIX_W),
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT_B), .START_DLY(DLY)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .fifo_full(fifo_full_b),
        .pixel_in(pixel_in_b), .addr(addr_b), .rom_rd(rom_rd_b), .pixel_out(pixel_out_b),
        .fifo_write(fifo_write_b), .frame_start(frame_start_b), .line_end(line_end_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: data = address, returned RD_LAT cycles after the strobe
    localparam logic [PIX_W-1:0] POISON = 24'hDEAD00;
    logic [PIX_W-1:0] rom_a [RD_LAT_A];
    logic [PIX_W-1:0] rom_b [RD_LAT_B];
    always @(posedge clk) begin
        rom_a[0] <= rom_rd_a ? PIX_W'(addr_a) : POISON;
        for (int i = 1; i < RD_LAT_A; i++) rom_a[i] <= rom_a[i-1];
        rom_b[0] <= rom_rd_b ? PIX_W'(addr_b) : POISON;
        for (int i = 1; i < RD_LAT_B; i++) rom_b[i] <= rom_b[i-1];
    end
    assign pixel_in_a = rom_a[RD_LAT_A-1];
    assign pixel_in_b = rom_b[RD_LAT_B-1];

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             fs;
        logic             le;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_a;

    typedef struct {
        int full_on;
        int full_off;
        int exp_wr;
        int exp_le;
        int exp_fs;
        int exp_rd;
        int exp_span;
    } vec_t;
    vec_t vecs[4];

    int errors = 0;
    int checks = 0;
    int wr_cnt, le_cnt, fs_cnt, rd_cnt, first_rd_addr, first_wr_cyc, last_wr_cyc;
    int full_on = 0, full_off = 0, full_phase = 0;
    int b_wr = 0, b_rd = 0, b_gaps = 0, b_prev = 0, b_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one clock; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (full_on == 0) begin
            fifo_full_a = 1'b0;
        end else begin
            fifo_full_a = (full_phase < full_on);
            full_phase  = (full_phase + 1) % (full_on + full_off);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; le_cnt = 0; fs_cnt = 0; rd_cnt = 0;
        first_rd_addr = -1; first_wr_cyc = 0; last_wr_cyc = 0;
    endtask

    task automatic push_frame();
        exp_t r;
        for (int y = 0; y < SRC_H_A; y++)
            for (int v = 0; v < V_A; v++)
                for (int x = 0; x < SRC_W_A; x++)
                    for (int h = 0; h < H_A; h++) begin
                        r.pix = PIX_W'(y * SRC_W_A + x);
                        r.fs  = (y == 0) && (v == 0) && (x == 0) && (h == 0);
                        r.le  = (x == SRC_W_A - 1) && (h == H_A - 1);
                        exp_q.push_back(r);
                    end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int t = 0;
        while (wr_cnt < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, wr_cnt >= n ? n : wr_cnt, n);
    endtask

    task automatic measure_first_write(input string name);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = fifo_write_a;
        end
        chk(name, seen ? n : -1, FIRST_WR);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fifo_write"}, int'(fifo_write_a), 0);
        chk({tag, "_rom_rd"}, int'(rom_rd_a), 0);
        chk({tag, "_addr"}, int'(addr_a), 0);
        chk({tag, "_pixel_out"}, int'(pixel_out_a), 0);
        chk({tag, "_frame_start"}, int'(frame_start_a), 0);
        chk({tag, "_line_end"}, int'(line_end_a), 0);
        chk({tag, "_b_fifo_write"}, int'(fifo_write_b), 0);
    endtask

    task automatic start_frame(input vec_t v);
        clear_counts();
        full_on = v.full_on;
        full_off = v.full_off;
        full_phase = 0;
        push_frame();
        enable_a = 1'b1;
        wait_writes(1, 100, "frame_begin");
        enable_a = 1'b0;
    endtask

    task automatic finish_frame(input vec_t v);
        wait_writes(v.exp_wr, 8 * FRAME_WR, "frame_writes");
        full_on = 0;
        repeat (30) tick();
        chk("writes_total", wr_cnt, v.exp_wr);
        chk("line_end_count", le_cnt, v.exp_le);
        chk("frame_start_count", fs_cnt, v.exp_fs);
        chk("rom_fetches", rd_cnt, v.exp_rd);
        chk("first_fetch_addr", first_rd_addr, 0);
        chk("queue_left", exp_q.size(), 0);
        if (v.exp_span > 0) chk("frame_span", last_wr_cyc - first_wr_cyc + 1, v.exp_span);
    endtask

    // scoreboard for dut_a
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_full_a) begin
                checks++;
                if (fifo_write_a) begin
                    errors++;
                    $display("FAIL write_while_full: fifo_write=1, expected 0");
                end
            end
            if (fifo_write_a) begin
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
                if (frame_start_a) fs_cnt++;
                if (line_end_a) le_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: pix=%0d, expected no write", pixel_out_a);
                end else begin
                    e_a = exp_q.pop_front();
                    if (pixel_out_a !== e_a.pix || frame_start_a !== e_a.fs || line_end_a !== e_a.le) begin
                        errors++;
                        $display("FAIL write_%0d: pix=%0d fs=%0b le=%0b, expected pix=%0d fs=%0b le=%0b",
                                 wr_cnt, pixel_out_a, frame_start_a, line_end_a, e_a.pix, e_a.fs, e_a.le);
                    end
                end
            end
            if (rom_rd_a) begin
                if (rd_cnt == 0) first_rd_addr = int'(addr_a);
                rd_cnt++;
            end
        end
    end

    // scoreboard for dut_b: raster order, one fetch per pixel
    always @(negedge clk) begin
        if (!rst_n) begin
            b_wr = 0;
            b_rd = 0;
        end else begin
            if (fifo_write_b) begin
                checks++;
                b_exp = b_wr % FRAME_B;
                if (pixel_out_b !== PIX_W'(b_exp) || frame_start_b !== (b_exp == 0) ||
                    line_end_b !== ((b_exp % SRC_W_B) == SRC_W_B - 1)) begin
                    errors++;
                    $display("FAIL b_write_%0d: pix=%0d fs=%0b le=%0b, expected pix=%0d",
                             b_wr, pixel_out_b, frame_start_b, line_end_b, b_exp);
                end
                if (b_exp != 0 && cyc - b_prev > 1) b_gaps++;
                b_prev = cyc;
                b_wr++;
            end
            if (rom_rd_b) begin
                checks++;
                if (addr_b !== ADDR_W'(b_rd % FRAME_B)) begin
                    errors++;
                    $display("FAIL b_fetch_%0d: addr=%0d, expected %0d", b_rd, addr_b, b_rd % FRAME_B);
                end
                b_rd++;
            end
        end
    end

    initial begin
        vecs[0] = '{0, 0, FRAME_WR, LINES, 1, FRAME_RD, FRAME_WR};
        vecs[1] = '{1, 2, FRAME_WR, LINES, 1, FRAME_RD, 0};
        vecs[2] = '{2, 1, FRAME_WR, LINES, 1, FRAME_RD, 0};
        vecs[3] = '{1, 1, FRAME_WR, LINES, 1, FRAME_RD, 0};

        clear_counts();
        repeat (3) tick();
        check_zero("reset");

        // first frame after reset: latency, no gaps, enable dropped after first write
        push_frame();
        enable_a = 1'b1;
        enable_b = 1'b1;
        rst_n = 1'b1;
        measure_first_write("first_write_latency");
        enable_a = 1'b0;
        finish_frame(vecs[0]);

        // table of backpressure patterns, each a full re-enabled frame
        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i]);
            finish_frame(vecs[i]);
        end

        // reset in the middle of a frame
        clear_counts();
        push_frame();
        enable_a = 1'b1;
        wait_writes(50, 400, "pre_reset_writes");
        rst_n = 1'b0;
        tick();
        check_zero("mid_reset");
        exp_q.delete();
        clear_counts();
        push_frame();
        rst_n = 1'b1;
        measure_first_write("restart_latency");
        enable_a = 1'b0;
        finish_frame(vecs[0]);

        // stall instance ran continuously since the last reset
        chk("b_frames_seen", b_wr >= 2 * FRAME_B ? 1 : 0, 1);
        chk("b_stall_gaps", b_gaps > 0 ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
